// File: rtl/cache_asociativo_if.sv
// rtl/cache_asociativo_if.sv - picorv32-style native memory port bundle
interface cache_asociativo_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/cache_asociativo.sv
// rtl/cache_asociativo.sv - N-way set-associative write-back cache with LRU and MMIO bypass
module cache_asociativo #(
  parameter int          CACHE_SIZE    = 1024,
  parameter int          BLOCK_BYTES   = 16,
  parameter int          WAYS          = 2,
  parameter logic [31:0] UNCACHED_BASE = 32'h1000_0000
) (
  input  logic               clk,
  input  logic               resetn,
  cache_asociativo_if.slave  cpu,
  cache_asociativo_if.master mp,
  output logic [31:0]        hits,
  output logic [31:0]        misses,
  output logic [31:0]        accesos
);

  localparam int BLOCK_WORDS = BLOCK_BYTES / 4;
  localparam int SETS_RAW    = CACHE_SIZE / (BLOCK_BYTES * WAYS);
  localparam int NUM_SETS    = (SETS_RAW < 1) ? 1 : SETS_RAW;
  localparam int OFFSET      = $clog2(BLOCK_BYTES);
  localparam int INDEX       = $clog2(NUM_SETS);
  localparam int TAG         = 32 - INDEX - OFFSET;
  localparam int WORD_W      = (OFFSET > 2) ? OFFSET - 2 : 1;
  localparam int SET_W       = (INDEX > 0) ? INDEX : 1;
  localparam int WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W       = WAY_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITE_BACK, REFILL, BYPASS} state_t;

  state_t state, state_n;

  logic [31:0]      data_arr  [WAYS][NUM_SETS][BLOCK_WORDS];
  logic [TAG-1:0]   tag_arr   [WAYS][NUM_SETS];
  logic             valid_arr [WAYS][NUM_SETS];
  logic             dirty_arr [WAYS][NUM_SETS];
  logic [AGE_W-1:0] age_arr   [WAYS][NUM_SETS];

  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              replay;
  logic [WORD_W-1:0] beat;
  logic [WAY_W-1:0]  vic_way;
  logic [TAG-1:0]    vic_tag;

  logic [SET_W-1:0]  cur_set;
  logic [WORD_W-1:0] cur_word;
  logic [TAG-1:0]    cur_tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              mp_done;
  logic              last_beat;

  assign cur_set   = SET_W'((req_addr >> OFFSET) & 32'(NUM_SETS - 1));
  assign cur_word  = WORD_W'((req_addr >> 2) & 32'(BLOCK_WORDS - 1));
  assign cur_tag   = TAG'(req_addr >> (OFFSET + INDEX));
  assign mp_done   = mp.mem_valid && mp.mem_ready;
  assign last_beat = (beat == WORD_W'(BLOCK_WORDS - 1));

  function automatic logic [31:0] line_addr(input logic [TAG-1:0] t,
                                            input logic [SET_W-1:0] s,
                                            input logic [WORD_W-1:0] w);
    line_addr = (32'(t) << (OFFSET + INDEX)) | (32'(s) << OFFSET) | (32'(w) << 2);
  endfunction

  // Tag compare across the set, plus victim choice: first invalid way, else oldest
  always_comb begin
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] max_way;
    logic [AGE_W-1:0] max_age;
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    max_way   = '0;
    max_age   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_arr[w][cur_set] && (tag_arr[w][cur_set] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_arr[w][cur_set]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_arr[w][cur_set] > max_age) begin
        max_age = age_arr[w][cur_set];
        max_way = WAY_W'(w);
      end
    end
    victim = inv_found ? inv_way : max_way;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (cpu.mem_valid && !cpu.mem_ready)
          state_n = (cpu.mem_addr >= UNCACHED_BASE) ? BYPASS : LOOKUP;
      end
      LOOKUP: begin
        if (hit)
          state_n = IDLE;
        else if (valid_arr[victim][cur_set] && dirty_arr[victim][cur_set])
          state_n = WRITE_BACK;
        else
          state_n = REFILL;
      end
      WRITE_BACK: if (mp_done && last_beat) state_n = REFILL;
      REFILL:     if (mp_done && last_beat) state_n = LOOKUP;
      BYPASS:     if (mp_done) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Request latch, bus outputs, counters and line metadata
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpu.mem_ready <= 1'b0;
      cpu.mem_rdata <= '0;
      mp.mem_valid  <= 1'b0;
      mp.mem_instr  <= 1'b0;
      mp.mem_addr   <= '0;
      mp.mem_wdata  <= '0;
      mp.mem_wstrb  <= '0;
      hits          <= '0;
      misses        <= '0;
      accesos       <= '0;
      req_addr      <= '0;
      req_wdata     <= '0;
      req_wstrb     <= '0;
      replay        <= 1'b0;
      beat          <= '0;
      vic_way       <= '0;
      vic_tag       <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          valid_arr[w][s] <= 1'b0;
          dirty_arr[w][s] <= 1'b0;
          age_arr[w][s]   <= '0;
        end
      end
    end else begin
      cpu.mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu.mem_valid && !cpu.mem_ready) begin
            req_addr     <= cpu.mem_addr;
            req_wdata    <= cpu.mem_wdata;
            req_wstrb    <= cpu.mem_wstrb;
            mp.mem_instr <= cpu.mem_instr;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_wstrb == 4'h0) cpu.mem_rdata <= data_arr[hit_way][cur_set][cur_word];
            else                   dirty_arr[hit_way][cur_set] <= 1'b1;
            cpu.mem_ready <= 1'b1;
            if (!replay) begin
              hits    <= hits + 32'd1;
              accesos <= accesos + 32'd1;
            end
            replay <= 1'b0;
            // Ways tied with the accessed one also age, so the all-zero
            // reset state settles into a strict recency order.
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_W'(w) == hit_way)
                age_arr[w][cur_set] <= '0;
              else if ((age_arr[w][cur_set] <= age_arr[hit_way][cur_set]) &&
                       (age_arr[w][cur_set] != '1))
                age_arr[w][cur_set] <= age_arr[w][cur_set] + 1'b1;
            end
          end else begin
            misses  <= misses + 32'd1;
            accesos <= accesos + 32'd1;
            vic_way <= victim;
            vic_tag <= tag_arr[victim][cur_set];
            beat    <= '0;
          end
        end
        WRITE_BACK: begin
          if (!mp.mem_valid) begin
            mp.mem_valid <= 1'b1;
            mp.mem_addr  <= line_addr(vic_tag, cur_set, beat);
            mp.mem_wdata <= data_arr[vic_way][cur_set][beat];
            mp.mem_wstrb <= 4'hF;
          end else if (mp.mem_ready) begin
            mp.mem_valid <= 1'b0;
            beat         <= last_beat ? '0 : beat + 1'b1;
          end
        end
        REFILL: begin
          if (!mp.mem_valid) begin
            mp.mem_valid <= 1'b1;
            mp.mem_addr  <= line_addr(cur_tag, cur_set, beat);
            mp.mem_wstrb <= 4'h0;
          end else if (mp.mem_ready) begin
            mp.mem_valid <= 1'b0;
            beat         <= last_beat ? '0 : beat + 1'b1;
            if (last_beat) begin
              valid_arr[vic_way][cur_set] <= 1'b1;
              dirty_arr[vic_way][cur_set] <= 1'b0;
              replay                      <= 1'b1;
            end
          end
        end
        BYPASS: begin
          if (!mp.mem_valid) begin
            mp.mem_valid <= 1'b1;
            mp.mem_addr  <= req_addr;
            mp.mem_wdata <= req_wdata;
            mp.mem_wstrb <= req_wstrb;
          end else if (mp.mem_ready) begin
            mp.mem_valid  <= 1'b0;
            cpu.mem_ready <= 1'b1;
            cpu.mem_rdata <= mp.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Line data and tags: byte-merged write hits and refill beats
  always_ff @(posedge clk) begin
    if ((state == LOOKUP) && hit && (req_wstrb != 4'h0)) begin
      for (int b = 0; b < 4; b++)
        if (req_wstrb[b]) data_arr[hit_way][cur_set][cur_word][8*b +: 8] <= req_wdata[8*b +: 8];
    end
    if ((state == REFILL) && mp_done) begin
      data_arr[vic_way][cur_set][beat] <= mp.mem_rdata;
      if (last_beat) tag_arr[vic_way][cur_set] <= cur_tag;
    end
  end

endmodule

// File: tb/tb_cache_asociativo.sv
// tb/tb_cache_asociativo.sv - scoreboard bench for cache_asociativo
module tb_cache_asociativo;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] hits, misses, accesos;

  cache_asociativo_if cpu_if ();
  cache_asociativo_if mp_if ();

  cache_asociativo dut (
    .clk     (clk),
    .resetn  (resetn),
    .cpu     (cpu_if),
    .mp      (mp_if),
    .hits    (hits),
    .misses  (misses),
    .accesos (accesos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic [31:0] rdata;
    logic [31:0] h;
    logic [31:0] m;
    logic [31:0] a;
  } cpu_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } mp_exp_t;

  cpu_exp_t    cpu_q[$];
  mp_exp_t     mp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          tests = 0;
  int          fails = 0;
  int          beats_done = 0;
  int          wait_cnt = 0;

  function automatic logic [31:0] minit(input logic [31:0] a);
    minit = a ^ 32'hA500_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) mem_rd = mem_model[a];
    else                     mem_rd = minit(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_mp(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    mp_exp_t e;
    e.addr = a; e.strb = s; e.wdata = d;
    mp_q.push_back(e);
  endtask

  task automatic push_refill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) push_mp(base + 32'(4 * i), 4'h0, 32'h0);
  endtask

  // Main-memory responder: variable wait states, checks each beat against the queue
  initial begin
    mp_if.mem_ready = 1'b0;
    mp_if.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mp_if.mem_ready) begin
        mp_if.mem_ready = 1'b0;
      end else if (mp_if.mem_valid) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          if (mp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL mp_unexpected_beat: got addr %h strb %h, required no beat",
                     mp_if.mem_addr, mp_if.mem_wstrb);
          end else begin
            mp_exp_t e;
            e = mp_q.pop_front();
            check("mp_addr", mp_if.mem_addr, e.addr);
            check("mp_strb", 32'(mp_if.mem_wstrb), 32'(e.strb));
            if (e.strb != 4'h0) check("mp_wdata", mp_if.mem_wdata, e.wdata);
          end
          if (mp_if.mem_wstrb != 4'h0) begin
            logic [31:0] w;
            w = mem_rd(mp_if.mem_addr);
            for (int b = 0; b < 4; b++)
              if (mp_if.mem_wstrb[b]) w[8*b +: 8] = mp_if.mem_wdata[8*b +: 8];
            mem_model[mp_if.mem_addr] = w;
            mp_if.mem_rdata = 32'h0;
          end else begin
            mp_if.mem_rdata = mem_rd(mp_if.mem_addr);
          end
          mp_if.mem_ready = 1'b1;
          beats_done++;
          wait_cnt = beats_done % 3;
        end
      end
    end
  end

  // CPU-side monitor: pops the expected response whenever mem_ready is seen
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_if.mem_ready) begin
        if (cpu_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL cpu_unexpected_ready: got rdata %h, required no response", cpu_if.mem_rdata);
        end else begin
          cpu_exp_t e;
          e = cpu_q.pop_front();
          if (e.chk) check("cpu_rdata", cpu_if.mem_rdata, e.rdata);
          check("hits", hits, e.h);
          check("misses", misses, e.m);
          check("accesos", accesos, e.a);
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                        input logic chk, input logic [31:0] rd,
                        input logic [31:0] h, input logic [31:0] m, input logic [31:0] a,
                        input int lat);
    cpu_exp_t e;
    int       n;
    bit       seen;
    e.chk = chk; e.rdata = rd; e.h = h; e.m = m; e.a = a;
    cpu_q.push_back(e);
    cpu_if.mem_valid = 1'b1;
    cpu_if.mem_addr  = addr;
    cpu_if.mem_wdata = wdata;
    cpu_if.mem_wstrb = strb;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 500) begin
      @(posedge clk);
      n++;
      #1;
      if (cpu_if.mem_ready) seen = 1'b1;
    end
    cpu_if.mem_valid = 1'b0;
    cpu_if.mem_wstrb = 4'h0;
    if (!seen) begin
      tests++; fails++;
      $display("FAIL req_timeout: addr %h got no mem_ready in %0d cycles", addr, n);
    end else if (lat >= 0) begin
      check("hit_latency", 32'(n), 32'(lat));
    end
    @(negedge clk);
    check("mp_beats_drained", 32'(mp_q.size()), 32'd0);
    @(negedge clk);
    check("ready_single_pulse", 32'(cpu_if.mem_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;
    int n;
    cpu_if.mem_valid = 1'b0;
    cpu_if.mem_instr = 1'b0;
    cpu_if.mem_addr  = '0;
    cpu_if.mem_wdata = '0;
    cpu_if.mem_wstrb = '0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_ready", 32'(cpu_if.mem_ready), 32'd0);
    check("rst_mem_rdata", cpu_if.mem_rdata, 32'd0);
    check("rst_mp_valid", 32'(mp_if.mem_valid), 32'd0);
    check("rst_mp_addr", mp_if.mem_addr, 32'd0);
    check("rst_hits", hits, 32'd0);
    check("rst_misses", misses, 32'd0);
    check("rst_accesos", accesos, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Cold read, then hits within the same line
    push_refill(32'h100);
    do_req(32'h100, 4'h0, 32'h0, 1'b1, 32'hA500_0100, 0, 1, 1, -1);
    do_req(32'h104, 4'h0, 32'h0, 1'b1, 32'hA500_0104, 1, 1, 2, 2);
    do_req(32'h108, 4'b0010, 32'hAABB_CCDD, 1'b0, 32'h0, 2, 1, 3, 2);
    do_req(32'h108, 4'h0, 32'h0, 1'b1, 32'hA500_CC08, 3, 1, 4, 2);

    // Same set (stride 512 B): fill second way, touch 0x100, evict clean 0x300
    push_refill(32'h300);
    do_req(32'h300, 4'h0, 32'h0, 1'b1, 32'hA500_0300, 3, 2, 5, -1);
    do_req(32'h100, 4'h0, 32'h0, 1'b1, 32'hA500_0100, 4, 2, 6, 2);
    push_refill(32'h500);
    do_req(32'h500, 4'h0, 32'h0, 1'b1, 32'hA500_0500, 4, 3, 7, -1);

    // Evict dirty line 0x100: write-back first, then refill 0x700
    push_mp(32'h100, 4'hF, 32'hA500_0100);
    push_mp(32'h104, 4'hF, 32'hA500_0104);
    push_mp(32'h108, 4'hF, 32'hA500_CC08);
    push_mp(32'h10C, 4'hF, 32'hA500_010C);
    push_refill(32'h700);
    do_req(32'h700, 4'h0, 32'h0, 1'b1, 32'hA500_0700, 4, 4, 8, -1);

    // Uncached window: single beat each, counters untouched
    push_mp(32'h1000_0000, 4'b0001, 32'h0000_0041);
    do_req(32'h1000_0000, 4'b0001, 32'h0000_0041, 1'b0, 32'h0, 4, 4, 8, -1);
    push_mp(32'h1000_0004, 4'h0, 32'h0);
    do_req(32'h1000_0004, 4'h0, 32'h0, 1'b1, 32'hB500_0004, 4, 4, 8, -1);

    // Write miss allocates (evicts clean 0x500), merges upper bytes
    push_refill(32'h900);
    do_req(32'h900, 4'b1100, 32'h1234_5678, 1'b0, 32'h0, 4, 5, 9, -1);
    do_req(32'h900, 4'h0, 32'h0, 1'b1, 32'h1234_0900, 5, 5, 10, 2);

    // Reset while a refill is in flight
    push_refill(32'h040);
    start = beats_done;
    cpu_if.mem_valid = 1'b1;
    cpu_if.mem_addr  = 32'h040;
    cpu_if.mem_wstrb = 4'h0;
    n = 0;
    while (beats_done < start + 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!mp_if.mem_valid && n < 50);
    check("refill_beat2_in_flight", 32'(mp_if.mem_valid), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("async_rst_mp_valid", 32'(mp_if.mem_valid), 32'd0);
    check("async_rst_mem_ready", 32'(cpu_if.mem_ready), 32'd0);
    check("async_rst_misses", misses, 32'd0);
    check("async_rst_accesos", accesos, 32'd0);
    cpu_if.mem_valid = 1'b0;
    mp_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Cache is cold again; memory kept the written-back line
    push_refill(32'h100);
    do_req(32'h100, 4'h0, 32'h0, 1'b1, 32'hA500_0100, 0, 1, 1, -1);
    do_req(32'h108, 4'h0, 32'h0, 1'b1, 32'hA500_CC08, 1, 1, 2, 2);

    repeat (2) @(negedge clk);
    check("cpu_queue_empty", 32'(cpu_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
